// File: rtl/avalon_enforcer_if.sv
// rtl/avalon_enforcer_if.sv - Avalon-ST style stream interface carried by the enforcer
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output valid, output sop, output eop, output data, output empty, input rdy);
  modport slave  (input valid, input sop, input eop, input data, input empty, output rdy);
endinterface

// File: rtl/avalon_enforcer.sv
// rtl/avalon_enforcer.sv - repairs Avalon-ST packet framing and flags framing errors
module avalon_enforcer #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic          clk,
  input  logic          rst,
  avalon_st_if.slave    untrusted_msg,
  avalon_st_if.master   trusted_msg,
  output logic          packet_didnt_started,
  output logic          packet_in_packet
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               xfer;
  logic               drop;
  logic               sop_out;
  logic [EMPTY_W-1:0] empty_out;

  // Back-pressure is a pure wire: the enforcer never buffers a beat.
  assign untrusted_msg.rdy = trusted_msg.rdy;

  assign trusted_msg.valid = untrusted_msg.valid & ~drop;
  assign trusted_msg.sop   = sop_out;
  assign trusted_msg.eop   = untrusted_msg.eop;
  assign trusted_msg.data  = untrusted_msg.data;
  assign trusted_msg.empty = empty_out;

  // Decode the beat against the packet state; only transferred beats advance the state.
  always_comb begin
    state_next = state;
    xfer       = untrusted_msg.valid & trusted_msg.rdy;
    drop       = 1'b0;
    sop_out    = 1'b0;
    empty_out  = untrusted_msg.eop ? untrusted_msg.empty : '0;
    case (state)
      IDLE: begin
        drop    = ~untrusted_msg.sop;
        sop_out = untrusted_msg.sop;
        if (xfer && untrusted_msg.sop && !untrusted_msg.eop) begin
          state_next = IN_PACKET;
        end
      end
      IN_PACKET: begin
        // A stray sop inside an open packet is demoted to a continuation beat.
        sop_out = 1'b0;
        if (xfer && untrusted_msg.eop) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Packet state register; reset abandons any open packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Error flags pulse for one cycle after each offending transferred beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packet_didnt_started <= 1'b0;
      packet_in_packet     <= 1'b0;
    end else begin
      packet_didnt_started <= xfer & (state == IDLE) & ~untrusted_msg.sop;
      packet_in_packet     <= xfer & (state == IN_PACKET) & untrusted_msg.sop;
    end
  end
endmodule

// File: tb/tb_avalon_enforcer.sv
// tb/tb_avalon_enforcer.sv - scoreboard bench for avalon_enforcer
module tb_avalon_enforcer;
  localparam int DW = 16;

  typedef struct packed {
    logic           sop;
    logic           eop;
    logic [8*DW-1:0] data;
    logic [3:0]     empty;
  } beat_t;

  typedef struct packed {
    logic valid;
    logic didnt;
    logic pip;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic packet_didnt_started;
  logic packet_in_packet;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) u_in ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) u_out ();

  avalon_enforcer #(.DATA_WIDTH_IN_BYTES(DW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .untrusted_msg        (u_in),
    .trusted_msg          (u_out),
    .packet_didnt_started (packet_didnt_started),
    .packet_in_packet     (packet_in_packet)
  );

  always #5 clk = ~clk;

  beat_t beat_q[$];
  cyc_t  cyc_q[$];
  logic  done = 1'b0;

  // Reference model state: is a packet currently open, and which flags the last transfer earned.
  logic  open = 1'b0;
  logic  pend_didnt = 1'b0;
  logic  pend_pip = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic step(input logic v, input logic s, input logic e, input logic [8*DW-1:0] d,
                      input logic [3:0] em, input logic r, input logic rs);
    cyc_t  c;
    beat_t b;
    logic  nd;
    logic  np;
    @(posedge clk);
    #1;
    if (!rs) begin
      open       = 1'b0;
      pend_didnt = 1'b0;
      pend_pip   = 1'b0;
    end
    rst         = rs;
    u_in.valid  = v;
    u_in.sop    = s;
    u_in.eop    = e;
    u_in.data   = d;
    u_in.empty  = em;
    u_out.rdy   = r;
    c.valid = v && (open || s);
    c.didnt = pend_didnt;
    c.pip   = pend_pip;
    cyc_q.push_back(c);
    nd = 1'b0;
    np = 1'b0;
    b.eop   = e;
    b.data  = d;
    b.empty = e ? em : 4'd0;
    if (v && r) begin
      if (open) begin
        b.sop = 1'b0;
        beat_q.push_back(b);
        np = rs && s;
        open = rs && !e;
      end else if (s) begin
        b.sop = 1'b1;
        beat_q.push_back(b);
        open = rs && !e;
      end else begin
        nd = rs;
      end
    end
    pend_didnt = nd;
    pend_pip   = np;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b1);
  endtask

  // Stimulus: directed framing scenarios followed by randomized traffic.
  initial begin : driver
    logic [8*DW-1:0] rd;
    u_in.valid = 1'b0;
    u_in.sop   = 1'b0;
    u_in.eop   = 1'b0;
    u_in.data  = '0;
    u_in.empty = '0;
    u_out.rdy  = 1'b0;
    step(1'b1, 1'b0, 1'b0, {DW{8'h11}}, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, {DW{8'h12}}, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b1);
    // Clean packet
    step(1'b1, 1'b1, 1'b0, {DW{8'h22}}, 4'd5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, {DW{8'h22}}, 4'd5, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, {DW{8'h22}}, 4'd5, 1'b1, 1'b1);
    idle(2);
    // Repeated sop with a valid gap
    step(1'b1, 1'b1, 1'b0, {DW{8'h33}}, 4'd1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, {DW{8'h34}}, 4'd1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, {DW{8'h35}}, 4'd1, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, {DW{8'h36}}, 4'd7, 1'b1, 1'b1);
    idle(2);
    // Orphan beat, twice
    step(1'b1, 1'b0, 1'b0, {DW{8'h44}}, 4'd0, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, {DW{8'h45}}, 4'd2, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, {DW{8'h46}}, 4'd0, 1'b1, 1'b1);
    idle(2);
    // Back-pressure, then the same sequence accepted
    step(1'b1, 1'b1, 1'b0, {DW{8'h2D}}, 4'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, {DW{8'h2D}}, 4'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, {DW{8'h2D}}, 4'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, {DW{8'h2D}}, 4'd6, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, {DW{8'h2D}}, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, {DW{8'h2D}}, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, {DW{8'h2D}}, 4'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, {DW{8'h2D}}, 4'd6, 1'b1, 1'b1);
    idle(2);
    // Reset mid-packet
    step(1'b1, 1'b1, 1'b0, {DW{8'h55}}, 4'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, {DW{8'h56}}, 4'd0, 1'b1, 1'b1);
    idle(2);
    // Single-beat packet followed by a fresh sop
    step(1'b1, 1'b1, 1'b1, {DW{8'h66}}, 4'd3, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, {DW{8'h67}}, 4'd3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, {DW{8'h68}}, 4'd9, 1'b1, 1'b1);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int w = 0; w < DW / 4; w++) rd[w*32 +: 32] = $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, rd,
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);
    end
    idle(3);
    done = 1'b1;
  end

  // Monitor: one per-cycle expectation per negedge, one beat popped per output transfer.
  initial begin : monitor
    cyc_t  c;
    beat_t b;
    beat_t a;
    forever begin
      @(negedge clk);
      if (done && cyc_q.size() == 0) break;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        checks++;
        if (u_out.valid !== c.valid) begin
          errors++;
          $display("FAIL out_valid t=%0t actual %b required %b", $time, u_out.valid, c.valid);
        end
        checks++;
        if (u_in.rdy !== u_out.rdy) begin
          errors++;
          $display("FAIL rdy_pass t=%0t actual %b required %b", $time, u_in.rdy, u_out.rdy);
        end
        checks++;
        if (packet_didnt_started !== c.didnt) begin
          errors++;
          $display("FAIL packet_didnt_started t=%0t actual %b required %b", $time, packet_didnt_started, c.didnt);
        end
        checks++;
        if (packet_in_packet !== c.pip) begin
          errors++;
          $display("FAIL packet_in_packet t=%0t actual %b required %b", $time, packet_in_packet, c.pip);
        end
      end
      if (u_out.valid === 1'b1 && u_out.rdy === 1'b1) begin
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat t=%0t actual data %h required no beat", $time, u_out.data);
        end else begin
          b = beat_q.pop_front();
          a.sop   = u_out.sop;
          a.eop   = u_out.eop;
          a.data  = u_out.data;
          a.empty = u_out.empty;
          if (a !== b) begin
            errors++;
            $display("FAIL beat t=%0t actual sop=%b eop=%b empty=%0d data=%h required sop=%b eop=%b empty=%0d data=%h",
                     $time, a.sop, a.eop, a.empty, a.data, b.sop, b.eop, b.empty, b.data);
          end
        end
      end
    end
    checks++;
    if (beat_q.size() != 0) begin
      errors++;
      $display("FAIL missing_beats actual %0d left required 0", beat_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/avalon_enforcer.md
AVALON_ENFORCER -- requirements
Module: avalon_enforcer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_IN_BYTES, default 16, giving the bytes per beat; it SHALL equal the parameter of both attached avalon_st_if instances.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port untrusted_msg, avalon_st_if slave modport: input stream, possibly malformed.
REQ-005 The block SHALL have port trusted_msg, avalon_st_if master modport: output stream, guaranteed well-framed.
REQ-006 The block SHALL have port packet_didnt_started, output, 1 bit: error pulse, a data beat arrived outside a packet without sop.
REQ-007 The block SHALL have port packet_in_packet, output, 1 bit: error pulse, sop arrived while a packet is open.
REQ-008 Both avalon_st_if instances SHALL carry valid (1), sop (1), eop (1), data (8*DATA_WIDTH_IN_BYTES), empty ($clog2(DATA_WIDTH_IN_BYTES)) from master to slave, and rdy (1) from slave to master.

Function
REQ-009 Handshake: a beat SHALL transfer only in a cycle with untrusted_msg.valid=1 and trusted_msg.rdy=1.
REQ-010 untrusted_msg.rdy SHALL equal trusted_msg.rdy combinationally, with zero latency and no buffering.
REQ-011 The FSM SHALL have two states, IDLE (no open packet) and IN_PACKET; reset state is IDLE.
REQ-012 State SHALL change only on a transferred beat; cycles with valid=0 or rdy=0 SHALL hold the state.
REQ-013 IDLE, beat with sop=1, eop=0: the beat SHALL be forwarded unchanged, and the next state SHALL be IN_PACKET.
REQ-014 IDLE, beat with sop=1, eop=1: the beat SHALL be forwarded as a single-beat packet, and the state SHALL stay IDLE.
REQ-015 IDLE, beat with sop=0: the beat SHALL be dropped (trusted_msg.valid=0 that cycle), packet_didnt_started SHALL pulse, and the state SHALL stay IDLE.
REQ-016 IN_PACKET, beat with sop=0, eop=0: the beat SHALL be forwarded unchanged.
REQ-017 IN_PACKET, beat with eop=1: the beat SHALL be forwarded, and the next state SHALL be IDLE.
REQ-018 IN_PACKET, beat with sop=1: the beat SHALL be forwarded with trusted_msg.sop forced to 0 as a continuation of the open packet, packet_in_packet SHALL pulse, and eop SHALL be handled as in REQ-016/REQ-017.
REQ-019 trusted_msg.valid SHALL equal untrusted_msg.valid AND NOT (dropped-beat condition of REQ-015), combinationally.
REQ-020 trusted_msg.data SHALL pass through unmodified.
REQ-021 trusted_msg.empty SHALL equal untrusted_msg.empty when the output eop=1, and 0 otherwise.
REQ-022 Each error flag SHALL be registered: 1 for exactly one clk cycle, in the cycle after the offending transfer; a flag SHALL re-pulse on each further offending transfer.
REQ-023 Error detection SHALL consider transferred beats only; beats stalled by rdy=0 or with valid=0 SHALL raise no flag.
REQ-024 An idle gap (valid=0) inside a packet SHALL NOT close the packet.
REQ-025 Output sop/eop/empty values SHALL be don't-care when trusted_msg.valid=0; the implementation SHALL drive them as decoded above.

Reset
REQ-026 On rst=0, the FSM SHALL go to IDLE immediately and asynchronously, and packet_didnt_started and packet_in_packet SHALL be 0.
REQ-027 Outputs are combinational from the inputs and state, so while in reset a valid beat with sop=1 SHALL be forwarded, and one with sop=0 SHALL be dropped.
REQ-028 Reset asserted mid-packet SHALL abandon the open packet, so the first post-reset beat lacking sop SHALL be dropped with packet_didnt_started.

Verification
REQ-029 Clean packet: rdy=1, data={16{8'h22}}, beats sop / 3x mid / eop (empty=5) -> output identical beat-for-beat, empty=5 on the eop beat only, no flags, FSM ends IDLE.
REQ-030 Repeated sop: beats sop, mid, sop, valid gap, eop -> 4 beats out, with the third beat's sop forced 0, packet_in_packet high one cycle after the third beat, and no packet_didnt_started.
REQ-031 Orphan beat: from IDLE, a valid beat with sop=0, eop=0 -> trusted_msg.valid=0, packet_didnt_started=1 the next cycle only, state IDLE.
REQ-032 Back-pressure: rdy=0 with data={16{8'h2D}} and a sop, sop, mid, eop sequence -> untrusted_msg.rdy=0, no flags, state unchanged; after raising rdy the sequence is processed per REQ-013..REQ-018.
REQ-033 Reset mid-packet: sop beat, then rst=0 for 2 cycles, then a mid beat -> mid beat dropped, packet_didnt_started pulses.
REQ-034 Single-beat packet: sop=1, eop=1, empty=3 -> forwarded with empty=3, state stays IDLE, the next sop beat raises no packet_in_packet.
